// File: rtl/bcd_to_bin_dabbler.sv
// Sequential BCD-to-binary converter (reverse double dabble: shift right, subtract 3 from digits >= 8).
// Build option BCD2BIN_SAT_EN: saturate bin to all-ones on overflow instead of wrapping.
module bcd_to_bin_dabbler #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10,
  parameter int OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [OUT_W-1:0]      bin,
  output logic                  ovf,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // A digit that reads >= 8 after the shift was an odd-tens carry; remove the 3 it gained.
  function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd8) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [BCD_W-1:0] bcd_part_q, bcd_part_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] bin_q, bin_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BCD_W-1:0] shift_part_s;
  logic [BIN_W-1:0] shift_acc_s;
  logic             ovf_s;
  logic [OUT_W-1:0] bin_s;

  // One shift-and-correct step of the whole {bcd_part, acc} register and the result it would latch.
  always_comb begin
    shift_part_s = correct_digits({1'b0, bcd_part_q[BCD_W-1:1]});
    shift_acc_s  = {bcd_part_q[0], acc_q[BIN_W-1:1]};
    ovf_s        = ((shift_acc_s >> OUT_W) != {BIN_W{1'b0}});
`ifdef BCD2BIN_SAT_EN
    if (ovf_s) begin
      bin_s = {OUT_W{1'b1}};
    end else begin
      bin_s = shift_acc_s[OUT_W-1:0];
    end
`else
    bin_s = shift_acc_s[OUT_W-1:0];
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    bcd_part_d = bcd_part_q;
    acc_d      = acc_q;
    count_d    = count_q;
    bin_d      = bin_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (has_bad_digit(bcd)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            bin_d   = {OUT_W{1'b0}};
            ovf_d   = 1'b0;
          end else begin
            state_d    = ST_CONV;
            bcd_part_d = bcd;
            acc_d      = {BIN_W{1'b0}};
            count_d    = {CNT_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        bcd_part_d = shift_part_s;
        acc_d      = shift_acc_s;
        count_d    = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          state_d = ST_DONE;
          bin_d   = bin_s;
          ovf_d   = ovf_s;
          err_d   = 1'b0;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and registered outputs; reset abandons any conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bcd_part_q <= {BCD_W{1'b0}};
      acc_q      <= {BIN_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      bin_q      <= {OUT_W{1'b0}};
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_part_q <= bcd_part_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      bin_q      <= bin_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bin  = bin_q;
  assign ovf  = ovf_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_to_bin_dabbler.sv
// Bench for bcd_to_bin_dabbler: decimal-arithmetic reference model, per-cycle compare, directed and random stimulus.
module tb_bcd_to_bin_dabbler;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int OUT_W  = 8;
`ifdef BCD2BIN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [OUT_W-1:0] bin;
    logic             ovf;
    logic             err;
  } res_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [4*DIGITS-1:0] bcd = '0;
  logic [OUT_W-1:0]    bin;
  logic                ovf, err, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_bin_dabbler #(.DIGITS(DIGITS), .BIN_W(BIN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd(bcd),
    .bin(bin), .ovf(ovf), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: read the digits as a decimal number.
  function automatic res_t ref_conv(input logic [4*DIGITS-1:0] b);
    res_t r;
    int   v;
    int   d;
    r.err = 1'b0;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'((b >> (4 * i)) & 12'hF);
      if (d > 9) r.err = 1'b1;
      v = v * 10 + d;
    end
    if (r.err) begin
      r.bin = '0;
      r.ovf = 1'b0;
    end else begin
      r.ovf = (v >= (1 << OUT_W));
      r.bin = (r.ovf && SAT) ? {OUT_W{1'b1}} : OUT_W'(v % (1 << OUT_W));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles of busy remaining and the visible result registers.
  int   m_left;
  res_t m_out, m_pend, cur_res;
  assign cur_res = ref_conv(bcd);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_out  <= '0;
      m_pend <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pend <= cur_res;
        if (cur_res.err) begin
          m_left <= 1;
          m_out  <= cur_res;
        end else begin
          m_left <= BIN_W + 1;
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_out <= m_pend;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("done", 32'(done), 32'(m_left == 1));
    chk("bin",  32'(bin),  32'(m_out.bin));
    chk("ovf",  32'(ovf),  32'(m_out.ovf));
    chk("err",  32'(err),  32'(m_out.err));
    if (done && !m_out.err) chk("bcd_part_zero", 32'(dut.bcd_part_q), 32'd0);
  end

  // Launch one conversion (DUT must be idle or in its last busy cycle) and wait for done.
  task automatic run_conv(input logic [11:0] v, input logic [7:0] e_bin, input logic e_ovf,
                          input logic e_err, input int e_lat);
    int k;
    @(posedge clk); #1;
    start = 1'b1;
    bcd   = v;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (done) break;
    end
    chk("latency", 32'(k), 32'(e_lat));
    chk("lit_bin", 32'(bin), 32'(e_bin));
    chk("lit_ovf", 32'(ovf), 32'(e_ovf));
    chk("lit_err", 32'(err), 32'(e_err));
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_bin",  32'(bin),  32'd0);

    run_conv(12'h255, 8'hFF, 1'b0, 1'b0, 11);
    run_conv(12'h000, 8'h00, 1'b0, 1'b0, 11);
    run_conv(12'h128, 8'h80, 1'b0, 1'b0, 11);
    run_conv(12'h256, SAT ? 8'hFF : 8'h00, 1'b1, 1'b0, 11);
    run_conv(12'h999, SAT ? 8'hFF : 8'hE7, 1'b1, 1'b0, 11);
    run_conv(12'h1A3, 8'h00, 1'b0, 1'b1, 1);
    run_conv(12'h042, 8'h2A, 1'b0, 1'b0, 11);

    // Start ignored during conversion; bcd changes mid-conversion.
    @(posedge clk); #1;
    start = 1'b1; bcd = 12'h200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; bcd = 12'h111;
    @(posedge clk); #1 start = 1'b0; bcd = 12'h987;
    k = 0;
    while (k < 40 && !done) begin
      @(negedge clk);
      k++;
    end
    chk("ignored_start_bin", 32'(bin), 32'hC8);
    @(posedge clk); #1;
    @(negedge clk);
    chk("no_requeue_busy", 32'(busy), 32'd0);

    // Asynchronous reset during conversion.
    @(posedge clk); #1;
    start = 1'b1; bcd = 12'h255;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_bin",  32'(bin),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_conv(12'h007, 8'h07, 1'b0, 1'b0, 11);

    // Random traffic: random start and bcd every cycle, checked by the per-cycle compare.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      for (int d = 0; d < DIGITS; d++) begin
        if ($urandom_range(0, 7) == 0) bcd[4*d +: 4] = 4'($urandom_range(10, 15));
        else bcd[4*d +: 4] = 4'($urandom_range(0, 9));
      end
    end
    #1 start = 1'b0;
    k = 0;
    while (k < 40 && busy) begin
      @(negedge clk);
      k++;
    end
    chk("final_idle", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
